// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, optional even parity.
// The serial line is oversampled at CLKS_PER_BIT clocks per bit and sampled
// near the middle of each bit after a 2-flop synchronizer.
// Optional feature macro: UART_RX_PARITY_EN (adds an even parity bit between
// the last data bit and the stop bit; when undefined o_Parity_Err is tied low).
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx_Serial,
    input  logic       Rx_Ready,
    output logic [7:0] dataOut,
    output logic       o_Rx_Valid,
    output logic       o_Rx_Busy,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err,
    output logic       o_Overrun
);

    localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = 8'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
`endif

    state_t      state;
    logic        rx_meta;
    logic        rx_sync;
    logic [7:0]  counter;
    logic [2:0]  bit_index;
    logic [7:0]  shift_reg;
`ifdef UART_RX_PARITY_EN
    logic        parity_bad;
`endif

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

    assign o_Rx_Busy = (state != IDLE);

    // Frame FSM plus output holding register; error flags are one-cycle pulses
    // that become visible in the CLEANUP cycle together with the commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= 8'd0;
            bit_index   <= 3'd0;
            shift_reg   <= 8'h00;
            dataOut     <= 8'h00;
            o_Rx_Valid  <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Parity_Err <= 1'b0;
            parity_bad   <= 1'b0;
`endif
        end else begin
            o_Frame_Err <= 1'b0;
            o_Overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Parity_Err <= 1'b0;
`endif
            if (o_Rx_Valid && Rx_Ready) begin
                o_Rx_Valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    counter   <= 8'd0;
                    bit_index <= 3'd0;
                    if (!rx_sync) begin
                        state <= START;
                    end
                end

                START: begin
                    if (counter == HALF_LAST) begin
                        counter <= 8'd0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end

                DATA: begin
                    if (counter == BIT_LAST) begin
                        counter              <= 8'd0;
                        shift_reg[bit_index] <= rx_sync;
                        if (bit_index == 3'd7) begin
                            bit_index <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (counter == BIT_LAST) begin
                        counter    <= 8'd0;
                        parity_bad <= ^{shift_reg, rx_sync};
                        state      <= STOP;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
`endif

                STOP: begin
                    if (counter == BIT_LAST) begin
                        counter <= 8'd0;
                        state   <= CLEANUP;
                        if (!rx_sync) begin
                            o_Frame_Err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad) begin
                            o_Parity_Err <= 1'b1;
`endif
                        end else begin
                            dataOut    <= shift_reg;
                            o_Rx_Valid <= 1'b1;
                            if (o_Rx_Valid && !Rx_Ready) begin
                                o_Overrun <= 1'b1;
                            end
                        end
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end

                CLEANUP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign o_Parity_Err = 1'b0;
`endif

endmodule
